hls_fp32_sub_chn_o_rsci: RTL and testbench
==========================================

# hls_fp32_sub_chn_o_rsci

Output-channel interface for the fp32 subtract core: the producer side of the per-channel `*_rsci_wen_comp` handshake that the core staller ANDs into `core_wen`. It accepts one fp32 result per committed core cycle into a 2-entry skid FIFO. It drains that FIFO to the downstream consumer over a valid/ready port. It reports `chn_o_rsci_wen_comp` so the core stalls only when the FIFO cannot take a result.

## Interface
- `WIDTH`, default 32: result data width.
- `nvdla_core_clk` in 1: clock.
- `nvdla_core_rstn` in 1: reset, asynchronous, active-low.
- `core_wen` in 1: core commits this cycle (AND of all channel wen_comp).
- `core_wten` in 1: registered `~core_wen`; 1 = core was stalled in the previous cycle.
- `chn_o_rsci_iswt0` in 1: core presents a result to write this cycle.
- `chn_o_rsci_d` in WIDTH: result data; held stable by the core while stalled.
- `chn_o_rsci_wen_comp` out 1: this channel permits the core to advance.
- `chn_o_rsc_z` out WIDTH: downstream data (head entry).
- `chn_o_rsc_lz` out 1: downstream valid.
- `chn_o_rsc_vz` in 1: downstream ready.
- `chn_o_stall_cnt` out 16: channel-caused stall cycles. Present only with `HLS_FP32_SUB_CHN_O_PERF_EN`.

## Operation
- Storage: 2 entries `buf[0..1]`, 1-bit read pointer `rd_ptr`, 1-bit write pointer `wr_ptr`, 2-bit `count` (0..2).
- `full = (count == 2)`; `empty = (count == 0)`.
- `chn_o_rsci_wen_comp = ~chn_o_rsci_iswt0 | ~full`.
  - Purely combinational from registered state and `iswt0`.
  - Must not depend on `core_wen` or `chn_o_rsc_vz`; this avoids a loop through the staller.
- push = `core_wen & chn_o_rsci_iswt0`.
  - Writes `chn_o_rsci_d` into `buf[wr_ptr]` and toggles `wr_ptr`.
  - push is never issued while full, because wen_comp = 0 forces `core_wen` = 0.
- pop = `chn_o_rsc_lz & chn_o_rsc_vz`; toggles `rd_ptr`.
- `count` next value: `count + push - pop`.
- Simultaneous push and pop:
  - count unchanged.
  - Both pointers advance.
  - Legal at count 1. At count 2, push cannot occur.
- `chn_o_rsc_lz = ~empty`; `chn_o_rsc_z = buf[rd_ptr]`.
  - When empty, `z` holds the last popped value (not checked).
- Pointer wrap: 1-bit pointers wrap naturally, 1 -> 0.
- `core_wen = 1` with `iswt0 = 0`: no push, no effect.
- `core_wten` is used only by the perf counter. It does not alter data-path behaviour.
- Reset, asynchronous and effective mid-operation: all FIFO contents are discarded. Values after reset:
  - `count` = 0, pointers = 0, `buf` = 0.
  - `chn_o_rsc_lz` = 0, `chn_o_rsc_z` = 0.
  - `chn_o_rsci_wen_comp = ~iswt0 | 1` = 1.
  - `chn_o_stall_cnt` = 0.

## Timing
- Latency from push to `lz` = 1 is 1 cycle (registered, no bypass).
- Throughput: 1 result per cycle sustained while `vz` = 1.
- Two consecutive pushes are absorbed while `vz` = 0. The third request drops wen_comp in the same cycle (combinational).
- wen_comp recovers 1 cycle after the first pop from full.
- `chn_o_rsc_lz` and `chn_o_rsc_z` are registered-state outputs with no combinational path from inputs.
- Once `lz` = 1, it stays asserted with `z` stable until the pop.

## Configuration
- `HLS_FP32_SUB_CHN_O_PERF_EN` defined:
  - 16-bit `chn_o_stall_cnt` increments in each cycle where `core_wten & chn_o_rsci_iswt0 & full` is registered-true.
  - Implementation: a 1-bit flag `stall_q <= ~chn_o_rsci_wen_comp` is registered; the counter increments when `core_wten & stall_q`.
  - Saturates at 0xFFFF; reset to 0.
- Not defined:
  - Port `chn_o_stall_cnt`, the counter and the flag are absent.
  - Data-path behaviour is identical.

## Test plan
- Reset release, `iswt0` = 0: `lz` = 0, `wen_comp` = 1, `z` = 0.
- Push 0x3F800000 with `vz` = 1: `lz` = 1 the next cycle with `z` = 0x3F800000. Popped that cycle; `lz` = 0 after.
- `vz` = 0, push 0x40000000 then 0x40400000:
  - `count` = 2.
  - Third `iswt0` = 1 gives `wen_comp` = 0 and no push.
  - Raise `vz`: pops in order 0x40000000, 0x40400000.
  - `wen_comp` = 1 the cycle after the first pop.
- Count 1, push and pop in the same cycle for 8 cycles: `count` stays 1, outputs in push order, pointers wrap.
- Assert `nvdla_core_rstn` = 0 with count 2: `lz` drops immediately and `count` = 0. The next push appears after 1 cycle.
- With PERF_EN: hold full with `iswt0` = 1 for 10 cycles (`core_wten` = 1 from cycle 2) -> `chn_o_stall_cnt` = 9. Force 70000 stall cycles -> saturates at 0xFFFF.

Source files
------------

// File: rtl/hls_fp32_sub_chn_o_rsci.sv
// ----------------------------------------------------------------------------
// hls_fp32_sub_chn_o_rsci
//
// Output-channel interface of the fp32 subtract core. Results committed by
// the core land in a 2-entry skid FIFO. The FIFO drains to a downstream
// valid/ready consumer. The channel reports chn_o_rsci_wen_comp so the core
// staller holds the core only when the FIFO has no free entry.
//
// Optional feature macro: HLS_FP32_SUB_CHN_O_PERF_EN
//   When defined, a saturating 16-bit counter of channel-caused stall cycles
//   is added and exposed on chn_o_stall_cnt.
//
// Ports:
//   nvdla_core_clk        in   clock
//   nvdla_core_rstn       in   asynchronous active-low reset
//   core_wen              in   core commits this cycle
//   core_wten             in   core was stalled in the previous cycle
//                              (used only by the perf counter)
//   chn_o_rsci_iswt0      in   core presents a result this cycle
//   chn_o_rsci_d          in   result data, WIDTH bits
//   chn_o_rsci_wen_comp   out  this channel permits the core to advance
//   chn_o_rsc_z           out  downstream data (FIFO head), WIDTH bits
//   chn_o_rsc_lz          out  downstream valid
//   chn_o_rsc_vz          in   downstream ready
//   chn_o_stall_cnt       out  stall cycle count, 16 bits (perf build only)
// ----------------------------------------------------------------------------
module hls_fp32_sub_chn_o_rsci #(
  parameter int WIDTH = 32
) (
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rstn,
  input  logic             core_wen,
  input  logic             core_wten,
  input  logic             chn_o_rsci_iswt0,
  input  logic [WIDTH-1:0] chn_o_rsci_d,
  output logic             chn_o_rsci_wen_comp,
  output logic [WIDTH-1:0] chn_o_rsc_z,
  output logic             chn_o_rsc_lz,
  input  logic             chn_o_rsc_vz
`ifdef HLS_FP32_SUB_CHN_O_PERF_EN
  ,
  output logic [15:0]      chn_o_stall_cnt
`endif
);

  logic [WIDTH-1:0] mem [2];
  logic             rd_ptr;
  logic             wr_ptr;
  logic [1:0]       count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);

  // wen_comp deliberately uses only registered state and iswt0; pulling in
  // core_wen or vz would close a combinational loop through the staller.
  assign chn_o_rsci_wen_comp = ~chn_o_rsci_iswt0 | ~full;

  // The staller guarantees core_wen is low whenever we are full and the core
  // is presenting, so push never overflows.
  assign push = core_wen & chn_o_rsci_iswt0;
  assign pop  = chn_o_rsc_lz & chn_o_rsc_vz;

  assign chn_o_rsc_lz = ~empty;
  assign chn_o_rsc_z  = mem[rd_ptr];

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= chn_o_rsci_d;
    end
  end

  // 1-bit pointers wrap on their own; occupancy tracks push minus pop.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

`ifdef HLS_FP32_SUB_CHN_O_PERF_EN
  logic stall_q;

  // stall_q remembers that this channel blocked the core last cycle; the
  // core's own registered stall flag confirms the stall actually happened.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      stall_q         <= 1'b0;
      chn_o_stall_cnt <= 16'd0;
    end else begin
      stall_q <= ~chn_o_rsci_wen_comp;
      if (core_wten && stall_q && (chn_o_stall_cnt != 16'hFFFF)) begin
        chn_o_stall_cnt <= chn_o_stall_cnt + 16'd1;
      end
    end
  end
`else
  logic unused_wten;
  assign unused_wten = core_wten;
`endif

endmodule

// File: tb/tb_hls_fp32_sub_chn_o_rsci.sv
// ----------------------------------------------------------------------------
// tb_hls_fp32_sub_chn_o_rsci
//
// Directed self-checking bench for the fp32 subtract output channel. Inputs
// change 1 time unit after the rising edge and outputs are observed 1 unit
// after that, well away from the active edge. Expected values are
// hand-computed constants. Define HLS_FP32_SUB_CHN_O_PERF_EN to also cover
// the stall counter.
// ----------------------------------------------------------------------------
module tb_hls_fp32_sub_chn_o_rsci;

  logic        clk;
  logic        rstn;
  logic        core_wen;
  logic        core_wten;
  logic        iswt0;
  logic [31:0] d;
  logic        wen_comp;
  logic [31:0] z;
  logic        lz;
  logic        vz;
`ifdef HLS_FP32_SUB_CHN_O_PERF_EN
  logic [15:0] stall_cnt;
`endif

  int errors = 0;
  int checks = 0;

  hls_fp32_sub_chn_o_rsci #(.WIDTH(32)) dut (
    .nvdla_core_clk      (clk),
    .nvdla_core_rstn     (rstn),
    .core_wen            (core_wen),
    .core_wten           (core_wten),
    .chn_o_rsci_iswt0    (iswt0),
    .chn_o_rsci_d        (d),
    .chn_o_rsci_wen_comp (wen_comp),
    .chn_o_rsc_z         (z),
    .chn_o_rsc_lz        (lz),
    .chn_o_rsc_vz        (vz)
`ifdef HLS_FP32_SUB_CHN_O_PERF_EN
    ,
    .chn_o_stall_cnt     (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and step just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the core-side and consumer-side inputs, then let combinational
  // outputs settle before any check.
  task automatic applyStimulus(input logic cw, input logic sw, input logic [31:0] data, input logic ready);
    core_wen = cw;
    iswt0    = sw;
    d        = data;
    vz       = ready;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    rstn      = 1'b0;
    core_wten = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);

    // Reset state, both while held and after release.
    tick();
    checkOutput("rst_lz", {31'b0, lz}, 32'd0);
    checkOutput("rst_z", z, 32'h0);
    checkOutput("rst_wen", {31'b0, wen_comp}, 32'd1);
    rstn = 1'b1;
    tick();
    checkOutput("rel_lz", {31'b0, lz}, 32'd0);
    checkOutput("rel_wen", {31'b0, wen_comp}, 32'd1);
    checkOutput("rel_z", z, 32'h0);

    // Single push with the consumer ready: visible next cycle, popped then.
    applyStimulus(1'b1, 1'b1, 32'h3F800000, 1'b1);
    checkOutput("p1_wen", {31'b0, wen_comp}, 32'd1);
    checkOutput("p1_lz_before", {31'b0, lz}, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("p1_lz", {31'b0, lz}, 32'd1);
    checkOutput("p1_z", z, 32'h3F800000);
    tick();
    checkOutput("p1_lz_after", {31'b0, lz}, 32'd0);

    // Fill with the consumer stalled, then a third request must be refused.
    applyStimulus(1'b1, 1'b1, 32'h40000000, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b1, 32'h40400000, 1'b0);
    checkOutput("fill1_wen", {31'b0, wen_comp}, 32'd1);
    tick();
    applyStimulus(1'b0, 1'b1, 32'h40800000, 1'b0);
    checkOutput("full_wen", {31'b0, wen_comp}, 32'd0);
    checkOutput("full_lz", {31'b0, lz}, 32'd1);
    checkOutput("full_z", z, 32'h40000000);
    tick();
    checkOutput("full_hold_wen", {31'b0, wen_comp}, 32'd0);
    checkOutput("full_hold_z", z, 32'h40000000);

    // Consumer wakes: pop in order, wen_comp returns the cycle after.
    applyStimulus(1'b0, 1'b1, 32'h40800000, 1'b1);
    checkOutput("drain_wen_same", {31'b0, wen_comp}, 32'd0);
    tick();
    checkOutput("drain_wen", {31'b0, wen_comp}, 32'd1);
    checkOutput("drain_z2", z, 32'h40400000);
    checkOutput("drain_lz", {31'b0, lz}, 32'd1);

    // Staller now lets the held result through while popping: count stays 1.
    applyStimulus(1'b1, 1'b1, 32'h40800000, 1'b1);
    tick();
    checkOutput("sim_z", z, 32'h40800000);
    checkOutput("sim_wen", {31'b0, wen_comp}, 32'd1);

    // Eight cycles of simultaneous push and pop; pointers wrap repeatedly.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b1, 32'h41000000 + 32'(i), 1'b1);
      tick();
      checkOutput($sformatf("stream_z%0d", i), z, 32'h41000000 + 32'(i));
      checkOutput($sformatf("stream_lz%0d", i), {31'b0, lz}, 32'd1);
      applyStimulus(1'b1, 1'b1, 32'h41000000 + 32'(i), 1'b1);
      checkOutput($sformatf("stream_wen%0d", i), {31'b0, wen_comp}, 32'd1);
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    checkOutput("stream_empty_lz", {31'b0, lz}, 32'd0);

    // Asynchronous reset mid-operation while full.
    applyStimulus(1'b1, 1'b1, 32'hAAAA0001, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b1, 32'hAAAA0002, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b1, 32'hAAAA0003, 1'b0);
    checkOutput("prerst_wen", {31'b0, wen_comp}, 32'd0);
    rstn = 1'b0;
    #1;
    checkOutput("midrst_lz", {31'b0, lz}, 32'd0);
    checkOutput("midrst_z", z, 32'h0);
    checkOutput("midrst_wen", {31'b0, wen_comp}, 32'd1);
    rstn = 1'b1;
    applyStimulus(1'b1, 1'b1, 32'h12345678, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("postrst_lz", {31'b0, lz}, 32'd1);
    checkOutput("postrst_z", z, 32'h12345678);
    tick();
    checkOutput("postrst_hold_z", z, 32'h12345678);
    checkOutput("postrst_hold_lz", {31'b0, lz}, 32'd1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    checkOutput("postrst_pop_lz", {31'b0, lz}, 32'd0);

    // core_wen without a presented result must not push.
    applyStimulus(1'b1, 1'b0, 32'hDEADBEEF, 1'b1);
    tick();
    checkOutput("nopush_lz", {31'b0, lz}, 32'd0);

`ifdef HLS_FP32_SUB_CHN_O_PERF_EN
    checkOutput("perf_init", {16'b0, stall_cnt}, 32'd0);
    applyStimulus(1'b1, 1'b1, 32'h50000001, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b1, 32'h50000002, 1'b0);
    tick();
    // Full and presenting for 10 cycles; the core reports its stall from 2 on.
    core_wten = 1'b0;
    applyStimulus(1'b0, 1'b1, 32'h50000003, 1'b0);
    tick();
    core_wten = 1'b1;
    repeat (9) tick();
    checkOutput("perf_nine", {16'b0, stall_cnt}, 32'd9);
    repeat (70000) tick();
    checkOutput("perf_sat", {16'b0, stall_cnt}, 32'h0000FFFF);
    core_wten = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
